// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared ALU encodings, operand selects, control bundle and hazard FSM state
package pipeline_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SUB  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b10101;
  localparam logic [4:0] ALU_FWD  = 5'b11000;

  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // A bubble must never write state or touch memory.
  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_mux.sv
// rtl/forward_mux.sv - single-operand forwarding selector, EX/MEM over MEM/WB over register file
module forward_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       data,
  output logic                  forwarded
);

  logic exmem_hit;
  logic memwb_hit;

  // x0 is hardwired to zero, so a write targeting it is never a forwarding source.
  assign exmem_hit = exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == rs_addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == rs_addr);

  always_comb begin
    data      = rf_data;
    forwarded = 1'b0;
    if (exmem_hit) begin
      data      = exmem_result;
      forwarded = 1'b1;
    end else if (memwb_hit) begin
      data      = memwb_result;
      forwarded = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use bubble and stall
// Optional performance counters are enabled with the ID_EX_PERF_CNT_EN macro.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [XLEN-1:0]       ID_PC,
  input  logic [XLEN-1:0]       ID_RS1_DATA,
  input  logic [XLEN-1:0]       ID_RS2_DATA,
  input  logic [XLEN-1:0]       ID_IMM,
  input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RD_ADDR,
  input  logic                  ID_RS1_USED,
  input  logic                  ID_RS2_USED,
  input  logic                  ID_OP1_SEL,
  input  logic                  ID_OP2_SEL,
  input  logic [SEL_W-1:0]      ID_ALU_SELECT,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  ID_MEM_WRITE,
  input  logic                  FLUSH,
  input  logic                  HOLD,
  input  logic [REG_ADDR_W-1:0] EXMEM_RD_ADDR,
  input  logic                  EXMEM_REG_WRITE,
  input  logic [XLEN-1:0]       EXMEM_RESULT,
  input  logic [REG_ADDR_W-1:0] MEMWB_RD_ADDR,
  input  logic                  MEMWB_REG_WRITE,
  input  logic [XLEN-1:0]       MEMWB_RESULT,
  output logic [XLEN-1:0]       DATA1,
  output logic [XLEN-1:0]       DATA2,
  output logic [SEL_W-1:0]      SELECT,
  output logic [XLEN-1:0]       EX_STORE_DATA,
  output logic [XLEN-1:0]       EX_PC,
  output logic [REG_ADDR_W-1:0] EX_RD_ADDR,
  output logic                  EX_VALID,
  output logic                  EX_REG_WRITE,
  output logic                  EX_MEM_READ,
  output logic                  EX_MEM_WRITE,
  output logic                  STALL_OUT
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           PERF_BUBBLES,
  output logic [31:0]           PERF_FLUSHES,
  output logic [31:0]           PERF_FWD
`endif
);

  ctrl_t                 id_ctrl;
  ctrl_t                 ex_ctrl;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs1_addr;
  logic [REG_ADDR_W-1:0] ex_rs2_addr;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_op1_sel;
  logic                  ex_op2_sel;
  logic [SEL_W-1:0]      ex_select;
  hz_state_t             state;

  logic                  ex_is_load;
  logic                  rs_match;
  logic                  load_use;
  logic                  take_id;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;
  logic                  rs1_fwd;
  logic                  rs2_fwd;

  assign id_ctrl = '{valid: ID_VALID, reg_write: ID_REG_WRITE,
                     mem_read: ID_MEM_READ, mem_write: ID_MEM_WRITE};

  // Load data is not ready until MEM, so a dependent instruction must wait one cycle.
  assign ex_is_load = ex_ctrl.valid && ex_ctrl.mem_read && (ex_rd_addr != '0);
  assign rs_match   = (ID_RS1_USED && (ID_RS1_ADDR == ex_rd_addr)) ||
                      (ID_RS2_USED && (ID_RS2_ADDR == ex_rd_addr));
  assign load_use   = (state == RUN) && ex_is_load && ID_VALID && rs_match;
  assign take_id    = !FLUSH && !load_use;
  assign STALL_OUT  = HOLD || (load_use && !FLUSH);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_op1_sel  <= OP1_RS1;
      ex_op2_sel  <= OP2_RS2;
      ex_select   <= SEL_W'(ALU_ADD);
      state       <= RUN;
    end else begin
      if (!HOLD) begin
        ex_ctrl     <= take_id ? id_ctrl : CTRL_BUBBLE;
        ex_pc       <= take_id ? ID_PC : '0;
        ex_rs1_data <= take_id ? ID_RS1_DATA : '0;
        ex_rs2_data <= take_id ? ID_RS2_DATA : '0;
        ex_imm      <= take_id ? ID_IMM : '0;
        ex_rs1_addr <= take_id ? ID_RS1_ADDR : '0;
        ex_rs2_addr <= take_id ? ID_RS2_ADDR : '0;
        ex_rd_addr  <= take_id ? ID_RD_ADDR : '0;
        ex_op1_sel  <= take_id ? ID_OP1_SEL : OP1_RS1;
        ex_op2_sel  <= take_id ? ID_OP2_SEL : OP2_RS2;
        ex_select   <= take_id ? ID_ALU_SELECT : SEL_W'(ALU_ADD);
      end
      case (state)
        RUN:     if (load_use && !HOLD && !FLUSH) state <= BUBBLE;
        BUBBLE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr         (ex_rs1_addr),
    .rf_data         (ex_rs1_data),
    .exmem_rd_addr   (EXMEM_RD_ADDR),
    .exmem_reg_write (EXMEM_REG_WRITE),
    .exmem_result    (EXMEM_RESULT),
    .memwb_rd_addr   (MEMWB_RD_ADDR),
    .memwb_reg_write (MEMWB_REG_WRITE),
    .memwb_result    (MEMWB_RESULT),
    .data            (fwd_rs1),
    .forwarded       (rs1_fwd)
  );

  forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr         (ex_rs2_addr),
    .rf_data         (ex_rs2_data),
    .exmem_rd_addr   (EXMEM_RD_ADDR),
    .exmem_reg_write (EXMEM_REG_WRITE),
    .exmem_result    (EXMEM_RESULT),
    .memwb_rd_addr   (MEMWB_RD_ADDR),
    .memwb_reg_write (MEMWB_REG_WRITE),
    .memwb_result    (MEMWB_RESULT),
    .data            (fwd_rs2),
    .forwarded       (rs2_fwd)
  );

  assign DATA1         = (ex_op1_sel == OP1_PC)  ? ex_pc  : fwd_rs1;
  assign DATA2         = (ex_op2_sel == OP2_IMM) ? ex_imm : fwd_rs2;
  assign EX_STORE_DATA = fwd_rs2;
  assign SELECT        = ex_select;
  assign EX_PC         = ex_pc;
  assign EX_RD_ADDR    = ex_rd_addr;
  assign EX_VALID      = ex_ctrl.valid;
  assign EX_REG_WRITE  = ex_ctrl.reg_write;
  assign EX_MEM_READ   = ex_ctrl.mem_read;
  assign EX_MEM_WRITE  = ex_ctrl.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  // Counters advance only on cycles where the EX register itself advances.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PERF_BUBBLES <= '0;
      PERF_FLUSHES <= '0;
      PERF_FWD     <= '0;
    end else if (!HOLD) begin
      if (load_use && !FLUSH) PERF_BUBBLES <= PERF_BUBBLES + 32'd1;
      if (FLUSH) PERF_FLUSHES <= PERF_FLUSHES + 32'd1;
      if (ex_ctrl.valid && (rs1_fwd || rs2_fwd)) PERF_FWD <= PERF_FWD + 32'd1;
    end
  end
`else
  logic unused_fwd_flags;
  assign unused_fwd_flags = rs1_fwd | rs2_fwd;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (perf checks with ID_EX_PERF_CNT_EN)
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int S_D1 = 0, S_D2 = 1, S_SD = 2, S_PC = 3, S_SEL = 4, S_RD = 5;
  localparam int S_V = 6, S_RW = 7, S_MR = 8, S_MW = 9, S_STALL = 10;
  localparam int S_PB = 11, S_PF = 12, S_PW = 13;

  logic        CLK = 1'b0;
  logic        RESET, ID_VALID, ID_RS1_USED, ID_RS2_USED, ID_OP1_SEL, ID_OP2_SEL;
  logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE, FLUSH, HOLD;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR, ID_ALU_SELECT;
  logic [4:0]  EXMEM_RD_ADDR, MEMWB_RD_ADDR;
  logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
  logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
  logic [31:0] DATA1, DATA2, EX_STORE_DATA, EX_PC;
  logic [4:0]  SELECT, EX_RD_ADDR;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, STALL_OUT;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] PERF_BUBBLES, PERF_FLUSHES, PERF_FWD;
`endif

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event sample_ev;

  always #5 CLK = ~CLK;

  id_ex_stage dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL), .ID_ALU_SELECT(ID_ALU_SELECT),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .FLUSH(FLUSH), .HOLD(HOLD),
    .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RESULT(MEMWB_RESULT),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .EX_STORE_DATA(EX_STORE_DATA),
    .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR), .EX_VALID(EX_VALID),
    .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
    .STALL_OUT(STALL_OUT)
`ifdef ID_EX_PERF_CNT_EN
    , .PERF_BUBBLES(PERF_BUBBLES), .PERF_FLUSHES(PERF_FLUSHES), .PERF_FWD(PERF_FWD)
`endif
  );

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_D1:    return DATA1;
      S_D2:    return DATA2;
      S_SD:    return EX_STORE_DATA;
      S_PC:    return EX_PC;
      S_SEL:   return {27'd0, SELECT};
      S_RD:    return {27'd0, EX_RD_ADDR};
      S_V:     return {31'd0, EX_VALID};
      S_RW:    return {31'd0, EX_REG_WRITE};
      S_MR:    return {31'd0, EX_MEM_READ};
      S_MW:    return {31'd0, EX_MEM_WRITE};
      S_STALL: return {31'd0, STALL_OUT};
`ifdef ID_EX_PERF_CNT_EN
      S_PB:    return PERF_BUBBLES;
      S_PF:    return PERF_FLUSHES;
      S_PW:    return PERF_FWD;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains the scoreboard at each falling edge or on explicit request.
  exp_t        cur;
  logic [31:0] got;
  always begin
    @(negedge CLK or sample_ev);
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      got = actual(cur.sig);
      n_tests++;
      if (got !== cur.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, got, cur.val);
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sig = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_id();
    ID_VALID = 0; ID_PC = 0; ID_RS1_DATA = 0; ID_RS2_DATA = 0; ID_IMM = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_RD_ADDR = 0; ID_RS1_USED = 0; ID_RS2_USED = 0;
    ID_OP1_SEL = 0; ID_OP2_SEL = 0; ID_ALU_SELECT = 0;
    ID_REG_WRITE = 0; ID_MEM_READ = 0; ID_MEM_WRITE = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic o1, input logic o2, input logic [4:0] sel,
                       input logic rw, input logic mr, input logic mw);
    ID_VALID = 1; ID_PC = pc; ID_RS1_ADDR = rs1; ID_RS1_DATA = d1;
    ID_RS2_ADDR = rs2; ID_RS2_DATA = d2; ID_IMM = imm; ID_RD_ADDR = rd;
    ID_RS1_USED = u1; ID_RS2_USED = u2; ID_OP1_SEL = o1; ID_OP2_SEL = o2;
    ID_ALU_SELECT = sel; ID_REG_WRITE = rw; ID_MEM_READ = mr; ID_MEM_WRITE = mw;
  endtask

  task automatic fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exr,
                     input logic mww, input logic [4:0] mwrd, input logic [31:0] mwr);
    EXMEM_REG_WRITE = exw; EXMEM_RD_ADDR = exrd; EXMEM_RESULT = exr;
    MEMWB_REG_WRITE = mww; MEMWB_RD_ADDR = mwrd; MEMWB_RESULT = mwr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1; HOLD = 0; FLUSH = 0;
    clr_id();
    fwd(0, 0, 0, 0, 0, 0);
    tick(); tick();
    RESET = 0;
    chk("rst_valid", S_V, 0); chk("rst_sel", S_SEL, 0); chk("rst_d1", S_D1, 0);
    chk("rst_d2", S_D2, 0); chk("rst_stall", S_STALL, 0); chk("rst_rw", S_RW, 0);
    chk("rst_mr", S_MR, 0); chk("rst_pc", S_PC, 0);

    // 1: basic load, then asynchronous reset mid-cycle
    instr(32'h100, 5'd1, 32'd10, 5'd2, 32'd20, 32'd5, 5'd4, 1, 1, OP1_RS1, OP2_IMM, ALU_ADD, 1, 0, 0);
    tick();
    clr_id();
    chk("t1_d1", S_D1, 10); chk("t1_d2", S_D2, 5); chk("t1_sel", S_SEL, 0);
    chk("t1_valid", S_V, 1); chk("t1_pc", S_PC, 32'h100); chk("t1_store", S_SD, 20);
    chk("t1_rd", S_RD, 4);
    @(negedge CLK); #1;
    RESET = 1; #1;
    chk("t1_arst_valid", S_V, 0); chk("t1_arst_d1", S_D1, 0); chk("t1_arst_d2", S_D2, 0);
    chk("t1_arst_pc", S_PC, 0); chk("t1_arst_rw", S_RW, 0);
    -> sample_ev;
    tick();
    RESET = 0;

    // 2: forwarding priority, register frozen with HOLD while forwarding inputs change
    instr(32'h104, 5'd3, 32'h11, 5'd0, 32'h22, 32'd0, 5'd8, 1, 1, OP1_RS1, OP2_RS2, ALU_SUB, 1, 0, 0);
    tick();
    clr_id(); HOLD = 1;
    fwd(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    chk("t2_exmem_d1", S_D1, 32'hAA); chk("t2_nomatch_d2", S_D2, 32'h22);
    chk("t2_sel", S_SEL, 32'h10); chk("t2_hold_stall", S_STALL, 1);
    tick();
    fwd(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    chk("t2_memwb_d1", S_D1, 32'hBB);
    tick();
    fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    chk("t2_rf_d1", S_D1, 32'h11); chk("t2_x0_nofwd_d2", S_D2, 32'h22);
    tick();
    HOLD = 0;
    fwd(0, 0, 0, 0, 0, 0);

    // 3: load-use bubble then MEM/WB forward of load data
    instr(32'h200, 5'd1, 32'h40, 5'd0, 32'd0, 32'd8, 5'd5, 1, 0, OP1_RS1, OP2_IMM, ALU_ADD, 1, 1, 0);
    tick();
    instr(32'h204, 5'd2, 32'd7, 5'd5, 32'd0, 32'd0, 5'd6, 1, 1, OP1_RS1, OP2_RS2, ALU_ADD, 1, 0, 0);
    chk("t3_stall", S_STALL, 1); chk("t3_ex_load", S_MR, 1);
    tick();
    fwd(1, 5'd5, 32'h248, 0, 5'd0, 32'd0);
    chk("t3_bubble_valid", S_V, 0); chk("t3_bubble_stall", S_STALL, 0); chk("t3_bubble_rw", S_RW, 0);
    tick();
    clr_id();
    fwd(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
    chk("t3_valid", S_V, 1); chk("t3_d1", S_D1, 7); chk("t3_d2", S_D2, 32'h1234);
    chk("t3_store", S_SD, 32'h1234); chk("t3_rd", S_RD, 6); chk("t3_stall_after", S_STALL, 0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);

    // 4: load-use coinciding with a flush
    instr(32'h300, 5'd1, 32'h40, 5'd0, 32'd0, 32'd8, 5'd5, 1, 0, OP1_RS1, OP2_IMM, ALU_ADD, 1, 1, 0);
    tick();
    instr(32'h304, 5'd5, 32'd1, 5'd0, 32'd0, 32'd0, 5'd7, 1, 0, OP1_RS1, OP2_RS2, ALU_SUB, 1, 0, 0);
    FLUSH = 1;
    chk("t4_stall", S_STALL, 0);
    tick();
    FLUSH = 0; clr_id();
    chk("t4_valid", S_V, 0); chk("t4_sel", S_SEL, 0); chk("t4_rd", S_RD, 0);
    chk("t4_rw", S_RW, 0); chk("t4_mr", S_MR, 0);

    // 5: HOLD freezes the register across changing ID inputs; HOLD beats FLUSH
    instr(32'h400, 5'd1, 32'h55, 5'd2, 32'h66, 32'h44, 5'd9, 1, 1, OP1_PC, OP2_IMM, ALU_FWD, 1, 0, 0);
    tick();
    HOLD = 1;
    for (int c = 0; c < 3; c++) begin
      instr(32'h500 + 32'(c * 4), 5'd3, 32'h77, 5'd4, 32'h88, 32'h99, 5'(10 + c),
            1, 1, OP1_RS1, OP2_RS2, ALU_SUB, 0, 1, 1);
      chk("t5_hold_pc", S_PC, 32'h400); chk("t5_hold_stall", S_STALL, 1);
      chk("t5_hold_d1", S_D1, 32'h400); chk("t5_hold_d2", S_D2, 32'h44);
      chk("t5_hold_sel", S_SEL, 32'h18);
      tick();
    end
    FLUSH = 1;
    chk("t5_hf_stall", S_STALL, 1);
    tick();
    HOLD = 0; FLUSH = 0; clr_id();
    chk("t5_hf_pc", S_PC, 32'h400); chk("t5_hf_valid", S_V, 1); chk("t5_hf_rd", S_RD, 9);
    tick();

`ifdef ID_EX_PERF_CNT_EN
    // 6: performance counters
    RESET = 1;
    tick();
    RESET = 0;
    chk("t6_rst_pb", S_PB, 0); chk("t6_rst_pf", S_PF, 0); chk("t6_rst_pw", S_PW, 0);
    for (int i = 0; i < 2; i++) begin
      instr(32'h600, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 0, 0, OP1_RS1, OP2_RS2, ALU_ADD, 1, 1, 0);
      tick();
      instr(32'h604, 5'd5, 32'd0, 5'd0, 32'd0, 32'd0, 5'd6, 1, 0, OP1_RS1, OP2_RS2, ALU_ADD, 1, 0, 0);
      tick();
      tick();
    end
    instr(32'h700, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 5'd2, 0, 0, OP1_RS1, OP2_RS2, ALU_ADD, 1, 0, 0);
    FLUSH = 1;
    tick();
    FLUSH = 0;
    instr(32'h800, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 5'd8, 1, 0, OP1_RS1, OP2_RS2, ALU_ADD, 1, 0, 0);
    tick();
    fwd(1, 5'd3, 32'hF0, 0, 5'd0, 32'd0);
    repeat (4) tick();
    fwd(0, 0, 0, 0, 0, 0);
    clr_id();
    chk("t6_pb", S_PB, 2); chk("t6_pf", S_PF, 1); chk("t6_pw", S_PW, 4);
    tick();
`endif

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registers a decoded instruction from ID into the EX stage.
- Resolves operand forwarding from EX/MEM and MEM/WB.
- Drives DATA1/DATA2/SELECT of the execute-stage ALU.
- Detects load-use hazards, inserts a bubble, and signals IF/ID to stall.
- Honours branch flush and downstream hold.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- SEL_W, 5, ALU select width.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ID_VALID  input  1  ID slot holds a real instruction.
- ID_PC  input  XLEN  instruction PC.
- ID_RS1_DATA, ID_RS2_DATA  input  XLEN  register-file read data.
- ID_IMM  input  XLEN  sign-extended immediate.
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  input  REG_ADDR_W  register indices.
- ID_RS1_USED, ID_RS2_USED  input  1  the instruction actually reads rs1 / rs2.
- ID_OP1_SEL  input  1  0 = rs1, 1 = PC.
- ID_OP2_SEL  input  1  0 = rs2, 1 = immediate.
- ID_ALU_SELECT  input  SEL_W  ALU operation code.
- ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  input  1  control bits.
- FLUSH  input  1  branch/jump redirect; kill the instruction entering EX.
- HOLD  input  1  downstream stall; freeze the EX register.
- EXMEM_RD_ADDR  input  REG_ADDR_W  destination of the EX/MEM instruction.
- EXMEM_REG_WRITE  input  1  EX/MEM instruction writes a register.
- EXMEM_RESULT  input  XLEN  EX/MEM result.
- MEMWB_RD_ADDR  input  REG_ADDR_W  destination of the MEM/WB instruction.
- MEMWB_REG_WRITE  input  1  MEM/WB instruction writes a register.
- MEMWB_RESULT  input  XLEN  MEM/WB result.
- DATA1, DATA2  output  XLEN  ALU operands.
- SELECT  output  SEL_W  ALU operation code.
- EX_STORE_DATA  output  XLEN  forwarded rs2 value for stores.
- EX_PC  output  XLEN  registered PC.
- EX_RD_ADDR  output  REG_ADDR_W  registered destination.
- EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  output  1  registered control.
- STALL_OUT  output  1  freezes PC and IF/ID.

Behaviour:
- Reset (async, any cycle, including mid-stall): all registered fields 0, so EX_VALID=0, SELECT=5'b00000 (ADD), all control bits 0.
  - After reset, DATA1/DATA2 = 0.
  - STALL_OUT = 0 after reset.
- Latency: one cycle from ID inputs to EX register. DATA1/DATA2/EX_STORE_DATA are combinational from the EX register plus forwarding inputs.
- Per-cycle register update, priority order:
  - HOLD=1: register keeps its value.
  - Else FLUSH=1: load a bubble.
  - Else load_use=1: load a bubble.
  - Else: load the ID fields, with EX_VALID=ID_VALID.
- Bubble: VALID, REG_WRITE, MEM_READ and MEM_WRITE are 0, SELECT=0, RD_ADDR=0. Data fields are don't-care but driven 0.
- load_use is asserted when all of the following hold:
  - EX_VALID & EX_MEM_READ & (EX_RD_ADDR != 0).
  - ID_VALID.
  - (ID_RS1_USED & ID_RS1_ADDR == EX_RD_ADDR) | (ID_RS2_USED & ID_RS2_ADDR == EX_RD_ADDR).
- STALL_OUT = HOLD | (load_use & ~FLUSH). A flush cancels the load-use stall.
- Forwarding, applied independently to registered rs1 and rs2:
  - Use EXMEM_RESULT if EXMEM_REG_WRITE & EXMEM_RD_ADDR != 0 & address match.
  - Else use MEMWB_RESULT if MEMWB_REG_WRITE & MEMWB_RD_ADDR != 0 & address match.
  - Else use the registered RF data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- Operand selection:
  - DATA1 = OP1_SEL ? EX_PC : fwd_rs1.
  - DATA2 = OP2_SEL ? imm : fwd_rs2.
  - EX_STORE_DATA = fwd_rs2 always.
- Hazard FSM, two states:
  - RUN → BUBBLE on load_use & ~HOLD & ~FLUSH.
  - BUBBLE → RUN unconditionally next cycle.
  - In BUBBLE, load_use is guaranteed false because EX holds the bubble.
- The FSM state is exported only through STALL_OUT timing.
- With HOLD and FLUSH both high, HOLD wins. The flush must be re-presented by the control unit.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds the following outputs, each cleared on RESET:
  - PERF_BUBBLES [31:0]: increments on each load-use bubble insertion.
  - PERF_FLUSHES [31:0]: increments on each flush bubble.
  - PERF_FWD [31:0]: increments on each cycle EX_VALID and either operand uses a forwarded value.
- Counters wrap at 2^32. They are frozen while HOLD=1.
- Without the macro: no counter logic and no extra ports.

Decomposition:
- Package pipeline_pkg holds:
  - ALU select encodings (ALU_ADD=5'b00000 … ALU_SUB=5'b10000, ALU_FWD=5'b11000).
  - OP1_RS1/OP1_PC and OP2_RS2/OP2_IMM constants.
  - The bubble control constant.
  - The FSM state typedef (RUN, BUBBLE).
- One natural sub-module, forward_mux: a combinational single-operand forwarding selector instantiated twice (rs1, rs2).

Test Plan:
1. Reset → load ID (VALID=1, SELECT=ADD, OP2_SEL=1, IMM=5, rs1=x1 data 10) → next cycle DATA1=10, DATA2=5, SELECT=0, EX_VALID=1; assert RESET mid-cycle → all outputs 0 immediately.
2. EX/MEM rd=x3 result 0xAA and MEM/WB rd=x3 result 0xBB, EX rs1=x3 → DATA1=0xAA; drop EXMEM_REG_WRITE → 0xBB; set rd=x0 on both → registered RF data.
3. Load to x5 in EX, ID uses rs2=x5 → STALL_OUT=1 for exactly one cycle, EX_VALID=0 next cycle, then the instruction enters with MEM/WB forward of load data 0x1234.
4. Load-use condition plus FLUSH=1 → STALL_OUT=0, bubble loaded.
5. HOLD=1 for 3 cycles with changing ID inputs → EX register unchanged, STALL_OUT=1. HOLD+FLUSH → register held.
6. With ID_EX_PERF_CNT_EN: run 2 load-use bubbles, 1 flush, 4 forwarded cycles → PERF_BUBBLES=2, PERF_FLUSHES=1, PERF_FWD=4.
